// File: rtl/acc_pkg.sv
// Shared helpers for the windowed accumulator: signed range limits and sign extension.
// All helpers work on 64-bit values; callers keep the low bits they need.
package acc_pkg;

    function automatic logic [63:0] acc_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] acc_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        logic [63:0] shifted;
        shifted = v << (64 - w);
        return $signed(shifted) >>> (64 - w);
    endfunction

endpackage

// File: rtl/sat_add.sv
// Signed two-operand adder with overflow detect and optional clamp to the ACC_W range.
// Purely combinational.
module sat_add
    import acc_pkg::*;
#(
    parameter int ACC_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN_VAL = ACC_W'(acc_min(ACC_W));

    logic [ACC_W:0] w_sumExt;

    // One guard bit: the true sum fits in ACC_W+1 bits, so overflow is a sign-bit disagreement.
    assign w_sumExt = {i_a[ACC_W-1], i_a} + {i_b[ACC_W-1], i_b};
    assign o_ovf    = w_sumExt[ACC_W] ^ w_sumExt[ACC_W-1];

    always_comb begin
        o_sum = w_sumExt[ACC_W-1:0];
        if ((SATURATE != 0) && o_ovf) begin
            o_sum = w_sumExt[ACC_W] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/acc_window.sv
// Windowed accumulator: sums WIN accepted samples, hands the sum to a valid/ready
// dump register, then restarts. Optional saturation, sticky overflow, sync clear.
module acc_window
    import acc_pkg::*;
#(
    parameter int IN_W     = 28,
    parameter int ACC_W    = 32,
    parameter int WIN      = 4,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   A,
    output logic [ACC_W-1:0]  Y,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ACC_W-1:0]  dump_data,
    output logic              ovf
);

    localparam int               CNT_W    = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_dumpData;
    logic             r_dumpValid;
    logic             r_ovf;

    logic             w_last;
    logic             w_stall;
    logic             w_accept;
    logic [ACC_W-1:0] w_aExt;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf;

    // Only the window-closing beat waits on the consumer; earlier beats never stall.
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_stall  = w_last & r_dumpValid & ~dump_ready;
    assign in_ready = ~clr & ~w_stall;
    assign w_accept = in_valid & in_ready;

    assign w_aExt = ACC_W'(sext(64'(A), IN_W));

    sat_add #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_satAdd (
        .i_a   (r_acc),
        .i_b   (w_aExt),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    // A closing beat that lands while the old dump drains overwrites it with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_dumpData  <= '0;
            r_dumpValid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (r_dumpValid && dump_ready) begin
                r_dumpValid <= 1'b0;
            end
            if (clr) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (w_accept) begin
                if (w_ovf) begin
                    r_ovf <= 1'b1;
                end
                if (w_last) begin
                    r_dumpData  <= w_sum;
                    r_dumpValid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign Y          = r_acc;
    assign dump_valid = r_dumpValid;
    assign dump_data  = r_dumpData;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_acc_window.sv
// Bench for acc_window: four configurations share one random stimulus stream and are
// compared each cycle against an integer-arithmetic model, plus hand-computed spot values.
module tb_acc_window;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        inValid;
    logic        dumpReady;
    logic [27:0] aIn;

    logic [3:0]  inReadyV;
    logic [3:0]  dvV;
    logic [3:0]  ovfV;
    logic [31:0] y0, y3, dd0, dd3;
    logic [27:0] y1, y2, dd1, dd2;
    logic [63:0] yArr  [4];
    logic [63:0] ddArr [4];

    int nChecks = 0;
    int nErr    = 0;

    longint mAcc [4];
    int     mCnt [4];
    bit     mOvf [4];
    bit     mDv  [4];
    longint mDd  [4];

    always #5 clk = ~clk;

    acc_window #(.IN_W(28), .ACC_W(32), .WIN(4), .SATURATE(1)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(inValid), .in_ready(inReadyV[0]),
        .A(aIn), .Y(y0), .dump_valid(dvV[0]), .dump_ready(dumpReady),
        .dump_data(dd0), .ovf(ovfV[0]));

    acc_window #(.IN_W(28), .ACC_W(28), .WIN(2), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(inValid), .in_ready(inReadyV[1]),
        .A(aIn), .Y(y1), .dump_valid(dvV[1]), .dump_ready(dumpReady),
        .dump_data(dd1), .ovf(ovfV[1]));

    acc_window #(.IN_W(28), .ACC_W(28), .WIN(2), .SATURATE(0)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(inValid), .in_ready(inReadyV[2]),
        .A(aIn), .Y(y2), .dump_valid(dvV[2]), .dump_ready(dumpReady),
        .dump_data(dd2), .ovf(ovfV[2]));

    acc_window #(.IN_W(28), .ACC_W(32), .WIN(1), .SATURATE(1)) dut3 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(inValid), .in_ready(inReadyV[3]),
        .A(aIn), .Y(y3), .dump_valid(dvV[3]), .dump_ready(dumpReady),
        .dump_data(dd3), .ovf(ovfV[3]));

    assign yArr[0]  = 64'(y0);
    assign yArr[1]  = 64'(y1);
    assign yArr[2]  = 64'(y2);
    assign yArr[3]  = 64'(y3);
    assign ddArr[0] = 64'(dd0);
    assign ddArr[1] = 64'(dd1);
    assign ddArr[2] = 64'(dd2);
    assign ddArr[3] = 64'(dd3);

    function automatic int accW(input int k);
        return (k == 1 || k == 2) ? 28 : 32;
    endfunction

    function automatic int winOf(input int k);
        case (k)
            0:       return 4;
            1, 2:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit satOf(input int k);
        return k != 2;
    endfunction

    function automatic logic [63:0] toBits(input int k, input longint v);
        return 64'(v) & ((64'd1 << accW(k)) - 64'd1);
    endfunction

    function automatic bit expectReady(input int k);
        return !clr && !((mCnt[k] == winOf(k) - 1) && mDv[k] && !dumpReady);
    endfunction

    task automatic checkOutput(input string name, input int k,
                               input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s dut%0d at %0t: got 0x%0h, expected 0x%0h",
                     name, k, $time, act, exp);
        end
    endtask

    // Reference: exact integer sum per beat, then clamp or wrap into the ACC_W range.
    task automatic modelStep(input int k);
        longint hi, lo, sum, res, a;
        bit     accepted;
        hi       = (longint'(1) <<< (accW(k) - 1)) - 1;
        lo       = -hi - 1;
        accepted = inValid && expectReady(k);
        if (mDv[k] && dumpReady) mDv[k] = 1'b0;
        if (clr) begin
            mAcc[k] = 0;
            mCnt[k] = 0;
            mOvf[k] = 1'b0;
        end else if (accepted) begin
            a   = longint'($signed(aIn));
            sum = mAcc[k] + a;
            res = sum;
            if (sum > hi) begin
                mOvf[k] = 1'b1;
                res     = satOf(k) ? hi : sum - (longint'(1) <<< accW(k));
            end else if (sum < lo) begin
                mOvf[k] = 1'b1;
                res     = satOf(k) ? lo : sum + (longint'(1) <<< accW(k));
            end
            if (mCnt[k] == winOf(k) - 1) begin
                mDd[k]  = res;
                mDv[k]  = 1'b1;
                mAcc[k] = 0;
                mCnt[k] = 0;
            end else begin
                mAcc[k] = res;
                mCnt[k] = mCnt[k] + 1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                mAcc[k] = 0;
                mCnt[k] = 0;
                mOvf[k] = 1'b0;
                mDv[k]  = 1'b0;
                mDd[k]  = 0;
            end
        end else begin
            for (int k = 0; k < 4; k++) modelStep(k);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            checkOutput("in_ready",   k, 64'(inReadyV[k]), 64'(expectReady(k)));
            checkOutput("Y",          k, yArr[k],          toBits(k, mAcc[k]));
            checkOutput("dump_valid", k, 64'(dvV[k]),      64'(mDv[k]));
            checkOutput("dump_data",  k, ddArr[k],         toBits(k, mDd[k]));
            checkOutput("ovf",        k, 64'(ovfV[k]),     64'(mOvf[k]));
        end
    end

    task automatic driveInputs(input logic v, input logic [27:0] a,
                               input logic c, input logic dr);
        inValid   = v;
        aIn       = a;
        clr       = c;
        dumpReady = dr;
    endtask

    task automatic applyStimulus(input logic v, input logic [27:0] a,
                                 input logic c, input logic dr);
        driveInputs(v, a, c, dr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [27:0] aRnd;
        int          sel;

        rst = 1'b1;
        driveInputs(1'b0, 28'd0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_Y",        0, 64'(y0),          64'd0);
        checkOutput("rst_dv",       0, 64'(dvV[0]),      64'd0);
        checkOutput("rst_dd",       0, 64'(dd0),         64'd0);
        checkOutput("rst_ovf",      0, 64'(ovfV[0]),     64'd0);
        checkOutput("rst_in_ready", 0, 64'(inReadyV[0]), 64'd1);
        rst = 1'b0;

        $display("[TB] window sum 1,2,3,4");
        applyStimulus(1'b1, 28'd1, 1'b0, 1'b1);
        checkOutput("t1_Y1",   0, 64'(y0),     64'd1);
        checkOutput("t1_w1dd", 3, 64'(dd3),    64'd1);
        checkOutput("t1_w1dv", 3, 64'(dvV[3]), 64'd1);
        applyStimulus(1'b1, 28'd2, 1'b0, 1'b1);
        checkOutput("t1_Y2",   0, 64'(y0),     64'd3);
        checkOutput("t1_w1dd", 3, 64'(dd3),    64'd2);
        checkOutput("t1_w2dd", 1, 64'(dd1),    64'd3);
        applyStimulus(1'b1, 28'd3, 1'b0, 1'b1);
        checkOutput("t1_Y3",   0, 64'(y0),     64'd6);
        checkOutput("t1_dv3",  0, 64'(dvV[0]), 64'd0);
        applyStimulus(1'b1, 28'd4, 1'b0, 1'b1);
        checkOutput("t1_Y4",   0, 64'(y0),     64'd0);
        checkOutput("t1_dv4",  0, 64'(dvV[0]), 64'd1);
        checkOutput("t1_dd4",  0, 64'(dd0),    64'd10);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 28'd0, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b1, 28'd5, 1'b0, 1'b0);
        checkOutput("t2_dd1", 0, 64'(dd0),    64'd20);
        checkOutput("t2_dv1", 0, 64'(dvV[0]), 64'd1);
        repeat (3) applyStimulus(1'b1, 28'd5, 1'b0, 1'b0);
        checkOutput("t2_Y15", 0, 64'(y0),     64'd15);
        driveInputs(1'b1, 28'd5, 1'b0, 1'b0);
        #1;
        checkOutput("t2_stall_ready", 0, 64'(inReadyV[0]), 64'd0);
        applyStimulus(1'b1, 28'd5, 1'b0, 1'b0);
        checkOutput("t2_hold_Y",  0, 64'(y0),     64'd15);
        checkOutput("t2_hold_dd", 0, 64'(dd0),    64'd20);
        checkOutput("t2_hold_dv", 0, 64'(dvV[0]), 64'd1);
        applyStimulus(1'b1, 28'd5, 1'b0, 1'b1);
        checkOutput("t2_reload_dd", 0, 64'(dd0),    64'd20);
        checkOutput("t2_reload_dv", 0, 64'(dvV[0]), 64'd1);
        checkOutput("t2_reload_Y",  0, 64'(y0),     64'd0);
        applyStimulus(1'b0, 28'd0, 1'b0, 1'b1);
        checkOutput("t2_drain_dv", 0, 64'(dvV[0]), 64'd0);

        $display("[TB] positive saturation and wrap");
        applyStimulus(1'b0, 28'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 28'h7FFFFFF, 1'b0, 1'b1);
        applyStimulus(1'b1, 28'h0000001, 1'b0, 1'b1);
        checkOutput("t3_sat_dd",   1, 64'(dd1),     64'h7FFFFFF);
        checkOutput("t3_sat_ovf",  1, 64'(ovfV[1]), 64'd1);
        checkOutput("t3_wrap_dd",  2, 64'(dd2),     64'h8000000);
        checkOutput("t3_wrap_ovf", 2, 64'(ovfV[2]), 64'd1);

        $display("[TB] negative saturation and wrap");
        applyStimulus(1'b0, 28'd0, 1'b1, 1'b1);
        checkOutput("t4_clr_ovf", 1, 64'(ovfV[1]), 64'd0);
        applyStimulus(1'b1, 28'h8000000, 1'b0, 1'b1);
        applyStimulus(1'b1, 28'hFFFFFFF, 1'b0, 1'b1);
        checkOutput("t4_sat_dd",   1, 64'(dd1),     64'h8000000);
        checkOutput("t4_sat_ovf",  1, 64'(ovfV[1]), 64'd1);
        checkOutput("t4_wrap_dd",  2, 64'(dd2),     64'h7FFFFFF);
        checkOutput("t4_wrap_ovf", 2, 64'(ovfV[2]), 64'd1);

        $display("[TB] synchronous clear");
        applyStimulus(1'b0, 28'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 28'd7, 1'b0, 1'b1);
        applyStimulus(1'b1, 28'd7, 1'b0, 1'b1);
        checkOutput("t5_Y14", 0, 64'(y0), 64'd14);
        driveInputs(1'b1, 28'd7, 1'b1, 1'b1);
        #1;
        checkOutput("t5_clr_ready", 0, 64'(inReadyV[0]), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("t5_clr_Y",   0, 64'(y0),      64'd0);
        checkOutput("t5_clr_ovf", 2, 64'(ovfV[2]), 64'd0);
        repeat (4) applyStimulus(1'b1, 28'd1, 1'b0, 1'b1);
        checkOutput("t5_dd",  0, 64'(dd0),     64'd4);
        checkOutput("t5_ovf", 0, 64'(ovfV[0]), 64'd0);

        $display("[TB] reset mid-window");
        applyStimulus(1'b1, 28'd9, 1'b0, 1'b1);
        applyStimulus(1'b1, 28'd9, 1'b0, 1'b1);
        checkOutput("t6_Y18", 0, 64'(y0), 64'd18);
        driveInputs(1'b0, 28'd0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_Y",   0, 64'(y0),      64'd0);
        checkOutput("t6_dd",  0, 64'(dd0),     64'd0);
        checkOutput("t6_dv",  3, 64'(dvV[3]),  64'd0);
        checkOutput("t6_dd3", 3, 64'(dd3),     64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) applyStimulus(1'b1, 28'd1, 1'b0, 1'b1);
        checkOutput("t6_after_dd", 0, 64'(dd0),    64'd4);
        checkOutput("t6_after_dv", 0, 64'(dvV[0]), 64'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      aRnd = 28'h7FFFFFF;
            else if (sel == 1) aRnd = 28'h8000000;
            else               aRnd = 28'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, aRnd,
                          $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1);
        end
        repeat (3) applyStimulus(1'b0, 28'd0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErr);
        $finish;
    end

endmodule
